hazard_ctrl: RTL and testbench

//  Stall/flush sequencer for the 5-stage pipeline (IF, DEC, EX, MEM, WB).

---
 rtl/hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_hazard_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch kills,
// multi-cycle MUL hold in EX, debug halt handshake and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic [4:0]       RsAddrD,
    input  logic [4:0]       RtAddrD,
    input  logic             UsesRtD,
    input  logic             MemReadE,
    input  logic [4:0]       RAddrE,
    input  logic             MULOpE,
    input  logic             BranchTaken,
    input  logic             HaltReq,
    output logic             HaltAck,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             MulBusy,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int MW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MULWAIT = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t         state;
    state_t         stateNext;
    logic [MW-1:0]  mulCnt;
    logic [MW-1:0]  mulCntNext;
    logic [CNT_W-1:0] stallCnt;
    logic           loadUse;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // r0 is hardwired, so a load targeting it never creates a dependency.
    assign loadUse = MemReadE && (RAddrE != 5'd0) &&
                     ((RAddrE == RsAddrD) || (UsesRtD && (RAddrE == RtAddrD)));

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state    <= RUN;
            mulCnt   <= '0;
            stallCnt <= '0;
        end else begin
            state  <= stateNext;
            mulCnt <= mulCntNext;
            if (StallF) begin
                stallCnt <= satInc(stallCnt);
            end
        end
    end

    always_comb begin
        stateNext  = state;
        mulCntNext = mulCnt;
        HaltAck    = 1'b0;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushM     = 1'b0;
        MulBusy    = 1'b0;

        unique case (state)
            RUN: begin
                if (BranchTaken) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                    if (HaltReq) stateNext = HALT;
                end else if (MULOpE && (MUL_LATENCY > 1)) begin
                    // MUL wins over a pending halt; the halt is taken once EX drains.
                    StallF     = 1'b1;
                    StallD     = 1'b1;
                    StallE     = 1'b1;
                    FlushM     = 1'b1;
                    stateNext  = MULWAIT;
                    mulCntNext = MW'(MUL_LATENCY - 2);
                end else begin
                    if (loadUse) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                    if (HaltReq) stateNext = HALT;
                end
            end
            MULWAIT: begin
                StallF  = 1'b1;
                StallD  = 1'b1;
                StallE  = 1'b1;
                FlushM  = 1'b1;
                MulBusy = 1'b1;
                if (mulCnt == '0) begin
                    stateNext = RUN;
                end else begin
                    mulCntNext = mulCnt - MW'(1);
                end
            end
            HALT: begin
                StallF  = 1'b1;
                StallD  = 1'b1;
                StallE  = 1'b1;
                FlushM  = 1'b1;
                HaltAck = 1'b1;
                if (!HaltReq) stateNext = RUN;
            end
            default: begin
                stateNext = RUN;
            end
        endcase

        if (!nReset) begin
            HaltAck = 1'b0;
            StallF  = 1'b0;
            StallD  = 1'b0;
            StallE  = 1'b0;
            FlushD  = 1'b0;
            FlushE  = 1'b0;
            FlushM  = 1'b0;
            MulBusy = 1'b0;
        end
    end

    assign StallCycles = nReset ? stallCnt : '0;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MUL_LATENCY=4, CNT_W=4): hazards, MUL hold,
// halt handshake, reset override and stall-counter saturation.
module tb_hazard_ctrl;

    logic       Clock = 1'b0;
    logic       nReset;
    logic [4:0] RsAddrD, RtAddrD, RAddrE;
    logic       UsesRtD, MemReadE, MULOpE, BranchTaken, HaltReq;
    logic       HaltAck, StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy;
    logic [3:0] StallCycles;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.MUL_LATENCY(4), .CNT_W(4)) dut (
        .Clock(Clock), .nReset(nReset),
        .RsAddrD(RsAddrD), .RtAddrD(RtAddrD), .UsesRtD(UsesRtD),
        .MemReadE(MemReadE), .RAddrE(RAddrE), .MULOpE(MULOpE),
        .BranchTaken(BranchTaken), .HaltReq(HaltReq),
        .HaltAck(HaltAck), .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .MulBusy(MulBusy),
        .StallCycles(StallCycles)
    );

    always #5 Clock = ~Clock;

    // Packed as {HaltAck,StallF,StallD,StallE,FlushD,FlushE,FlushM,MulBusy}
    function automatic logic [7:0] outs();
        return {HaltAck, StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        RsAddrD = 5'd0; RtAddrD = 5'd0; RAddrE = 5'd0; UsesRtD = 1'b0;
        MemReadE = 1'b0; MULOpE = 1'b0; BranchTaken = 1'b0; HaltReq = 1'b0;
    endtask

    initial begin
        idle();
        nReset = 1'b0;
        MULOpE = 1'b1; HaltReq = 1'b1; MemReadE = 1'b1; RAddrE = 5'd3; RsAddrD = 5'd3;
        cyc(); cyc(); #1;
        chk("reset_outs", outs(), 8'h00);
        chk("reset_cnt", {4'd0, StallCycles}, 8'd0);

        cyc(); nReset = 1'b1; idle(); #1;
        chk("run_idle", outs(), 8'h00);
        chk("run_cnt", {4'd0, StallCycles}, 8'd0);

        // load-use on Rs
        cyc(); MemReadE = 1'b1; RAddrE = 5'd5; RsAddrD = 5'd5; #1;
        chk("loaduse_rs", outs(), 8'h64);
        chk("loaduse_cnt_before", {4'd0, StallCycles}, 8'd0);
        cyc(); idle(); #1;
        chk("loaduse_gone", outs(), 8'h00);
        chk("loaduse_cnt", {4'd0, StallCycles}, 8'd1);

        // Rt gating by UsesRtD
        cyc(); MemReadE = 1'b1; RAddrE = 5'd7; RtAddrD = 5'd7; RsAddrD = 5'd3; UsesRtD = 1'b0; #1;
        chk("rt_unused", outs(), 8'h00);
        UsesRtD = 1'b1; #1;
        chk("rt_used", outs(), 8'h64);
        cyc(); idle(); #1;
        chk("rt_cnt", {4'd0, StallCycles}, 8'd2);

        // r0 destination never stalls
        cyc(); MemReadE = 1'b1; RAddrE = 5'd0; RsAddrD = 5'd0; RtAddrD = 5'd0; UsesRtD = 1'b1; #1;
        chk("r0_nostall", outs(), 8'h00);

        // branch overrides load-use and MUL
        cyc(); BranchTaken = 1'b1; MemReadE = 1'b1; RAddrE = 5'd5; RsAddrD = 5'd5; MULOpE = 1'b1; #1;
        chk("branch_prio", outs(), 8'h0C);
        cyc(); idle(); #1;
        chk("branch_no_mulwait", outs(), 8'h00);
        chk("branch_cnt", {4'd0, StallCycles}, 8'd2);

        // MUL: 4 cycles of EX hold
        cyc(); MULOpE = 1'b1; #1;
        chk("mul_t0", outs(), 8'h72);
        cyc(); MULOpE = 1'b0; #1;
        chk("mul_t1", outs(), 8'h73);
        cyc(); #1;
        chk("mul_t2", outs(), 8'h73);
        cyc(); #1;
        chk("mul_t3", outs(), 8'h73);
        cyc(); #1;
        chk("mul_t4_run", outs(), 8'h00);
        chk("mul_cnt", {4'd0, StallCycles}, 8'd6);

        // halt requested during MUL is deferred until MUL completes
        cyc(); MULOpE = 1'b1; HaltReq = 1'b1; #1;
        chk("mulhalt_t0", outs(), 8'h72);
        cyc(); MULOpE = 1'b0; #1;
        chk("mulhalt_t1", outs(), 8'h73);
        cyc(); #1;
        chk("mulhalt_t2", outs(), 8'h73);
        cyc(); #1;
        chk("mulhalt_t3", outs(), 8'h73);
        cyc(); #1;
        chk("mulhalt_t4_run", outs(), 8'h00);
        cyc(); #1;
        chk("mulhalt_halt", outs(), 8'hF2);
        cyc(); HaltReq = 1'b0; #1;
        chk("halt_release_cycle", outs(), 8'hF2);
        cyc(); #1;
        chk("halt_to_run", outs(), 8'h00);
        chk("halt_cnt", {4'd0, StallCycles}, 8'd12);

        // reset while in HALT
        cyc(); HaltReq = 1'b1; #1;
        chk("halt2_req", outs(), 8'h00);
        cyc(); #1;
        chk("halt2_in", outs(), 8'hF2);
        cyc(); nReset = 1'b0; #1;
        chk("halt2_rst_outs", outs(), 8'h00);
        chk("halt2_rst_cnt", {4'd0, StallCycles}, 8'd0);
        cyc(); nReset = 1'b1; HaltReq = 1'b0; #1;
        chk("halt2_after_rst", outs(), 8'h00);
        chk("halt2_after_rst_cnt", {4'd0, StallCycles}, 8'd0);

        // reset while in MULWAIT aborts the MUL
        cyc(); MULOpE = 1'b1; #1;
        chk("mulrst_t0", outs(), 8'h72);
        cyc(); MULOpE = 1'b0; #1;
        chk("mulrst_t1", outs(), 8'h73);
        cyc(); nReset = 1'b0; #1;
        chk("mulrst_rst", outs(), 8'h00);
        cyc(); nReset = 1'b1; #1;
        chk("mulrst_run", outs(), 8'h00);
        chk("mulrst_cnt", {4'd0, StallCycles}, 8'd0);

        // saturation at 15 with CNT_W=4
        cyc(); HaltReq = 1'b1; #1;
        chk("sat_req", outs(), 8'h00);
        for (int i = 0; i < 20; i++) begin
            cyc(); #1;
            if (i == 14) chk("sat_mid", {4'd0, StallCycles}, 8'd14);
        end
        chk("sat_halt", outs(), 8'hF2);
        chk("sat_cnt", {4'd0, StallCycles}, 8'd15);
        cyc(); HaltReq = 1'b0; #1;
        cyc(); #1;
        chk("sat_run", outs(), 8'h00);
        chk("sat_hold", {4'd0, StallCycles}, 8'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
